vec_dot_stream: RTL

//   Streaming dot-product engine. Accepts element pairs (a[i], b[i]) one per cycle

---
 rtl/vec_dot_stream_pkg.sv | 20 ++
 rtl/vec_dot_stream_if.sv | 25 ++
 rtl/vec_dot_stream_vec_mul.sv | 25 ++
 rtl/vec_dot_stream.sv | 94 +++++++++
 4 files changed

// File: rtl/vec_dot_stream_pkg.sv
// Shared fixpoint definitions (Q16.16 signed) for the streaming dot-product slice.
// Arithmetic wraps on overflow; products are truncated toward minus infinity.
package vec_dot_stream_pkg;

    localparam int FIXPOINT_WIDTH = 32;
    localparam int FIXPOINT_FRAC  = 16;

    typedef logic signed [FIXPOINT_WIDTH-1:0] fix_t;

    function automatic fix_t fixpoint_mul(input fix_t a, input fix_t b);
        logic signed [2*FIXPOINT_WIDTH-1:0] prod;
        prod = (2*FIXPOINT_WIDTH)'(a) * (2*FIXPOINT_WIDTH)'(b);
        return fix_t'(prod[FIXPOINT_FRAC +: FIXPOINT_WIDTH]);
    endfunction

    function automatic fix_t fixpoint_add(input fix_t a, input fix_t b);
        return a + b;
    endfunction

endpackage

// File: rtl/vec_dot_stream_if.sv
// Element-pair input and dot-product result handshakes of vec_dot_stream.
// Signal names are from the engine's point of view (i_ = into the engine).
interface vec_dot_stream_if #(
    parameter int VEC_SIZE = 16
);
    logic                                 i_flush;
    logic                                 i_valid;
    logic                                 o_ready;
    vec_dot_stream_pkg::fix_t             i_elem_a;
    vec_dot_stream_pkg::fix_t             i_elem_b;
    logic                                 o_dot_valid;
    logic                                 i_dot_ready;
    vec_dot_stream_pkg::fix_t             o_dot;
    logic [$clog2(VEC_SIZE):0]            o_count;

    modport slave (
        input  i_flush, i_valid, i_elem_a, i_elem_b, i_dot_ready,
        output o_ready, o_dot_valid, o_dot, o_count
    );

    modport master (
        output i_flush, i_valid, i_elem_a, i_elem_b, i_dot_ready,
        input  o_ready, o_dot_valid, o_dot, o_count
    );
endinterface

// File: rtl/vec_dot_stream_vec_mul.sv
// Combinational element-wise multiply and fixpoint sum of two vectors.
module vec_mul
    import vec_dot_stream_pkg::*;
#(
    parameter int VEC_SIZE = 16
) (
    input  fix_t i_vec_a [VEC_SIZE],
    input  fix_t i_vec_b [VEC_SIZE],
    output fix_t o_vec_c [VEC_SIZE],
    output fix_t o_dot
);

    always_comb begin
        fix_t acc;
        fix_t prod;
        acc = '0;
        for (int i = 0; i < VEC_SIZE; i++) begin
            prod       = fixpoint_mul(i_vec_a[i], i_vec_b[i]);
            o_vec_c[i] = prod;
            acc        = fixpoint_add(acc, prod);
        end
        o_dot = acc;
    end

endmodule

// File: rtl/vec_dot_stream.sv
// Streaming dot-product engine: buffers VEC_SIZE element pairs, reduces them
// through vec_mul, and holds the registered result until the consumer takes it.
module vec_dot_stream
    import vec_dot_stream_pkg::*;
#(
    parameter int VEC_SIZE = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    vec_dot_stream_if.slave  bus
);

    localparam int IDX_W = $clog2(VEC_SIZE);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_SIZE - 1);

    typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    fix_t              buf_a [VEC_SIZE];
    fix_t              buf_b [VEC_SIZE];
    fix_t              dot_c;
    fix_t              dot_q;
    logic              dot_vld_q;
    logic              rdy;
    logic              accept;
    logic [CNT_W-1:0]  count;

    vec_mul #(.VEC_SIZE(VEC_SIZE)) u_vec_mul (
        .i_vec_a (buf_a),
        .i_vec_b (buf_b),
        .o_vec_c (),
        .o_dot   (dot_c)
    );

    // Ready is a function of state and flush only, never of i_valid.
    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        count     = CNT_W'(VEC_SIZE);
        accept    = 1'b0;
        case (state)
            LOAD: begin
                rdy    = !bus.i_flush;
                count  = {1'b0, idx};
                accept = rdy && bus.i_valid;
                if (accept && idx == LAST_IDX) state_nxt = CALC;
            end
            CALC:    state_nxt = OUT;
            OUT:     if (bus.i_dot_ready) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
        if (bus.i_flush) state_nxt = LOAD;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= LOAD;
            idx       <= '0;
            dot_q     <= '0;
            dot_vld_q <= 1'b0;
            for (int i = 0; i < VEC_SIZE; i++) begin
                buf_a[i] <= '0;
                buf_b[i] <= '0;
            end
        end else if (bus.i_flush) begin
            // Buffers and the last result are kept; the next vector overwrites every slot.
            state     <= LOAD;
            idx       <= '0;
            dot_vld_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                buf_a[idx] <= bus.i_elem_a;
                buf_b[idx] <= bus.i_elem_b;
                idx        <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            if (state == CALC) begin
                dot_q     <= dot_c;
                dot_vld_q <= 1'b1;
            end else if (state == OUT && bus.i_dot_ready) begin
                dot_vld_q <= 1'b0;
            end
        end
    end

    assign bus.o_ready     = rdy;
    assign bus.o_count     = count;
    assign bus.o_dot       = dot_q;
    assign bus.o_dot_valid = dot_vld_q;

endmodule
